// File: rtl/cherry_dispatch_pkg.sv
// Shared types and constants for the instruction dispatch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cherry_dispatch_pkg;

    localparam int DFLT_INSTR_W  = 32;
    localparam int DFLT_NUM_CH   = 3;
    localparam int DFLT_NUM_REGS = 4;
    localparam int DFLT_CH_W     = $clog2(DFLT_NUM_CH);
    localparam int DFLT_RA_W     = $clog2(DFLT_NUM_REGS);

    // Channel numbering as seen on out_valid / in_ch
    localparam int CH_DMA   = 0;
    localparam int CH_CACHE = 1;
    localparam int CH_MATH  = 2;

    // Canonical queue entry at the default widths; the queue builds a
    // parameter-sized twin with identical field order.
    typedef struct packed {
        logic [DFLT_INSTR_W-1:0] instr;
        logic [DFLT_CH_W-1:0]    ch;
        logic                    src_used;
        logic [DFLT_RA_W-1:0]    src_reg;
        logic                    dst_set;
        logic [DFLT_RA_W-1:0]    dst_reg;
    } dispatch_entry_t;

endpackage

// File: rtl/instr_scoreboard.sv
// Per-register busy bits for loads in flight; set on load issue, clear on retire.
// Latency: set/clear visible one cycle later; lookup is combinational.
// Backpressure: none; set wins over a same-cycle clear of the same register.
module instr_scoreboard
    import cherry_dispatch_pkg::*;
#(
    parameter  int NUM_REGS = DFLT_NUM_REGS,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            set_i,
    input  logic [RA_W-1:0] set_reg_i,
    input  logic            clr_i,
    input  logic [RA_W-1:0] clr_reg_i,
    input  logic [RA_W-1:0] lookup_reg_i,
    output logic            lookup_busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Next busy vector: clear first so a coincident set overrides it
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_reg_i] = 1'b0;
        if (set_i) busy_d[set_reg_i] = 1'b1;
    end

    // Busy register, cleared by reset only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign lookup_busy_o = busy_q[lookup_reg_i];

endmodule

// File: rtl/instr_dispatch_queue.sv
// FIFO of decoded instructions feeding a registered one-hot dispatch slot.
// Latency: push at edge N reaches out_valid after edge N+1; no bypass.
// Backpressure: in_ready drops when full/flush; head waits on slot, freeze and scoreboard hazards.
module instr_dispatch_queue
    import cherry_dispatch_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int INSTR_W  = DFLT_INSTR_W,
    parameter  int NUM_CH   = DFLT_NUM_CH,
    parameter  int NUM_REGS = DFLT_NUM_REGS,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int RA_W     = $clog2(NUM_REGS),
    localparam int CNT_W    = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               freeze,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CH_W-1:0]    in_ch,
    input  logic               in_src_used,
    input  logic [RA_W-1:0]    in_src_reg,
    input  logic               in_dst_set,
    input  logic [RA_W-1:0]    in_dst_reg,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               retire_valid,
    input  logic [RA_W-1:0]    retire_reg,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               hazard_stall,
    output logic               bad_ch_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [CH_W-1:0]    ch;
        logic               src_used;
        logic [RA_W-1:0]    src_reg;
        logic               dst_set;
        logic [RA_W-1:0]    dst_reg;
    } entry_t;

    // The slot never needs the source fields once the entry has left the FIFO
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [CH_W-1:0]    ch;
        logic               dst_set;
        logic [RA_W-1:0]    dst_reg;
    } slot_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    slot_t            slot_q, slot_d;
    logic             slot_vld_q, slot_vld_d;
    logic             bad_err_q, bad_err_d;

    entry_t           in_entry, head;
    logic [PTR_W-1:0] occ;
    logic             fifo_empty, full;
    logic             push, pop, issue;
    logic             hazard, head_bad, sb_busy;
    logic [NUM_CH-1:0] slot_onehot;

    // Extra pointer MSB separates full from empty; subtraction wraps naturally
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occ == '0);
    assign full       = (occ == PTR_W'(DEPTH));

    // Tie in_ready to the reset pin so it is low while reset is held
    assign in_ready = reset && !full && !flush;
    assign push     = in_valid && in_ready;

    assign in_entry = '{instr:    in_instr,
                        ch:       in_ch,
                        src_used: in_src_used,
                        src_reg:  in_src_reg,
                        dst_set:  in_dst_set,
                        dst_reg:  in_dst_reg};

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    // Decode the slot channel into its one-hot valid lane
    always_comb begin
        slot_onehot = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            slot_onehot[c] = (slot_q.ch == CH_W'(c));
        end
    end

    assign out_valid = slot_vld_q ? slot_onehot : '0;
    assign out_instr = slot_q.instr;

    // Only the addressed channel's ready counts; flush wins over a same-cycle issue
    assign issue = slot_vld_q && !freeze && !flush && |(out_valid & out_ready);

    // The slot term covers a load that is offered but whose busy bit is not set yet
    assign hazard = head.src_used &&
                    (sb_busy ||
                     (slot_vld_q && slot_q.dst_set && (slot_q.dst_reg == head.src_reg)));

    assign head_bad = (int'(head.ch) >= NUM_CH);

    assign pop = !fifo_empty && !freeze && !flush && (!slot_vld_q || issue) && !hazard;

    // Pointer, slot and error-flag next state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        bad_err_d  = bad_err_q;
        if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        if (issue) slot_vld_d = 1'b0;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head_bad) begin
                // Unroutable entry is consumed without reaching the slot
                bad_err_d = 1'b1;
            end else begin
                slot_d     = '{instr:   head.instr,
                               ch:      head.ch,
                               dst_set: head.dst_set,
                               dst_reg: head.dst_reg};
                slot_vld_d = 1'b1;
            end
        end
        if (flush) begin
            // in_ready is low during flush, so wr_ptr_q is final this cycle
            rd_ptr_d   = wr_ptr_q;
            slot_vld_d = 1'b0;
        end
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            bad_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            bad_err_q  <= bad_err_d;
        end
    end

    // Entry storage needs no reset; pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
    end

    instr_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i         (clk),
        .rst_ni        (reset),
        .set_i         (issue && slot_q.dst_set),
        .set_reg_i     (slot_q.dst_reg),
        .clr_i         (retire_valid),
        .clr_reg_i     (retire_reg),
        .lookup_reg_i  (head.src_reg),
        .lookup_busy_o (sb_busy)
    );

    assign count        = CNT_W'(occ);
    assign empty        = fifo_empty && !slot_vld_q;
    assign hazard_stall = !fifo_empty && hazard;
    assign bad_ch_err   = bad_err_q;

endmodule
